rotate_halfword_mask_imm_pipe: RTL and testbench

Pipelined SPU right-shift unit for halfword immediate forms, the right-going counterpart of the halfword left-shift immediate path. Executes Rotate and Mask Halfword Immediate (rothmi, logical right shift) and Rotate and Mask Algebraic Halfword Immediate (rotmahi, arithmetic right shift) on all eight halfwords of a 128-bit operand. Sits in the odd/even execute pipe between operand fetch and register-file writeback. Uses a two-stage elastic pipeline with valid/ready handshakes on both sides.

---
 rtl/rotate_halfword_mask_imm_pipe_if.sv | 24 ++
 rtl/rotate_halfword_mask_imm_pipe.sv | 115 +++++++++++
 tb/tb_rotate_halfword_mask_imm_pipe.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/rotate_halfword_mask_imm_pipe_if.sv
// Handshake bus for the halfword right-shift immediate pipe: issue side (in_*)
// and writeback side (out_*) grouped in one bundle.
interface rotate_halfword_mask_imm_pipe_if;
    logic         in_valid;
    logic         in_ready;
    logic         in_alg;
    logic [6:0]   in_imm7;
    logic [127:0] in_ra;
    logic [6:0]   in_rt_addr;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_rt;
    logic [6:0]   out_rt_addr;

    modport master (
        output in_valid, in_alg, in_imm7, in_ra, in_rt_addr, out_ready,
        input  in_ready, out_valid, out_rt, out_rt_addr
    );

    modport slave (
        input  in_valid, in_alg, in_imm7, in_ra, in_rt_addr, out_ready,
        output in_ready, out_valid, out_rt, out_rt_addr
    );
endinterface

// File: rtl/rotate_halfword_mask_imm_pipe.sv
// Two-stage elastic pipe for rothmi / rotmahi: S1 does the coarse (16/8) shift,
// S2 the fine (0-7) shift, independently on each of the eight halfwords.
module rotate_halfword_mask_imm_pipe (
    input  logic                                  clk,
    input  logic                                  rst,
    rotate_halfword_mask_imm_pipe_if.slave        bus_if
);
    localparam int unsigned HW_W   = 16;
    localparam int unsigned NUM_HW = 8;
    localparam int unsigned DATA_W = HW_W * NUM_HW;
    localparam int unsigned IMM_W  = 7;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned FINE_W = 3;

    // sel[1]: count >= 16 saturates to the fill pattern; sel[0]: shift by 8.
    function automatic logic [HW_W-1:0] coarse_shift(input logic [HW_W-1:0] hw,
                                                     input logic            alg,
                                                     input logic [1:0]      sel);
        logic [HW_W-1:0] fill;
        fill = alg ? {HW_W{hw[HW_W-1]}} : '0;
        if (sel[1])
            return fill;
        else if (sel[0])
            return {fill[7:0], hw[HW_W-1:8]};
        else
            return hw;
    endfunction

    // Signed intermediate keeps >>> arithmetic regardless of the caller's context.
    function automatic logic [HW_W-1:0] fine_shift(input logic [HW_W-1:0]   hw,
                                                   input logic              alg,
                                                   input logic [FINE_W-1:0] sh);
        logic signed [HW_W-1:0] s_hw;
        logic signed [HW_W-1:0] s_res;
        s_hw  = $signed(hw);
        s_res = s_hw >>> sh;
        if (alg)
            return s_res;
        else
            return hw >> sh;
    endfunction

    logic              s1_valid_q;
    logic              s1_alg_q;
    logic [FINE_W-1:0] s1_fine_q;
    logic [DATA_W-1:0] s1_data_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic              s2_valid_q;
    logic [DATA_W-1:0] out_rt_q;
    logic [ADDR_W-1:0] out_rt_addr_q;

    logic              s1_adv_c;
    logic              s2_adv_c;
    logic              s1_load_c;
    logic              s2_load_c;
    logic [CNT_W-1:0]  cnt_c;
    logic [DATA_W-1:0] s1_data_d;
    logic [DATA_W-1:0] out_rt_d;

    assign s2_adv_c  = !s2_valid_q || bus_if.out_ready;
    assign s1_adv_c  = !s1_valid_q || s2_adv_c;
    assign s1_load_c = bus_if.in_valid && s1_adv_c;
    assign s2_load_c = s1_valid_q && s2_adv_c;

    // Low five bits of the negated immediate equal those of the negated sext16.
    assign cnt_c = CNT_W'(IMM_W'(0) - bus_if.in_imm7);

    always_comb begin
        s1_data_d = '0;
        for (int h = 0; h < NUM_HW; h++)
            s1_data_d[h*HW_W +: HW_W] = coarse_shift(bus_if.in_ra[h*HW_W +: HW_W],
                                                     bus_if.in_alg, cnt_c[4:3]);
    end

    always_comb begin
        out_rt_d = '0;
        for (int h = 0; h < NUM_HW; h++)
            out_rt_d[h*HW_W +: HW_W] = fine_shift(s1_data_q[h*HW_W +: HW_W],
                                                  s1_alg_q, s1_fine_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_alg_q      <= 1'b0;
            s1_fine_q     <= '0;
            s1_data_q     <= '0;
            s1_addr_q     <= '0;
            s2_valid_q    <= 1'b0;
            out_rt_q      <= '0;
            out_rt_addr_q <= '0;
        end else begin
            if (s1_adv_c)
                s1_valid_q <= bus_if.in_valid;
            if (s1_load_c) begin
                s1_alg_q  <= bus_if.in_alg;
                s1_fine_q <= cnt_c[FINE_W-1:0];
                s1_data_q <= s1_data_d;
                s1_addr_q <= bus_if.in_rt_addr;
            end
            if (s2_adv_c)
                s2_valid_q <= s1_valid_q;
            if (s2_load_c) begin
                out_rt_q      <= out_rt_d;
                out_rt_addr_q <= s1_addr_q;
            end
        end
    end

    assign bus_if.in_ready    = s1_adv_c;
    assign bus_if.out_valid   = s2_valid_q;
    assign bus_if.out_rt      = out_rt_q;
    assign bus_if.out_rt_addr = out_rt_addr_q;
endmodule

// File: tb/tb_rotate_halfword_mask_imm_pipe.sv
// Directed bench for the halfword right-shift immediate pipe: shift boundaries,
// lane isolation, backpressure ordering and mid-stream reset.
module tb_rotate_halfword_mask_imm_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rotate_halfword_mask_imm_pipe_if bus_if();

    rotate_halfword_mask_imm_pipe u_dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus_if)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    localparam logic [127:0] LANE_RA  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] LANE_EXP = 128'h0012_0456_089A_0CDE_0FED_0BA9_0765_0321;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic alg, input logic [6:0] imm,
                         input logic [127:0] ra, input logic [6:0] addr);
        bus_if.in_valid   = vld;
        bus_if.in_alg     = alg;
        bus_if.in_imm7    = imm;
        bus_if.in_ra      = ra;
        bus_if.in_rt_addr = addr;
    endtask

    // One op through an otherwise empty pipe with out_ready high.
    task automatic op_check(input string tag, input logic alg, input logic [6:0] imm,
                            input logic [127:0] ra, input logic [6:0] addr,
                            input logic [127:0] exp);
        @(negedge clk);
        drive(1'b1, alg, imm, ra, addr);
        check({tag, "_in_ready"}, 128'(bus_if.in_ready), 128'(1));
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        check({tag, "_lat1_valid"}, 128'(bus_if.out_valid), 128'(0));
        @(negedge clk);
        check({tag, "_valid"}, 128'(bus_if.out_valid), 128'(1));
        check({tag, "_rt"}, bus_if.out_rt, exp);
        check({tag, "_addr"}, 128'(bus_if.out_rt_addr), 128'(addr));
    endtask

    // Backpressure ops: count 1 algebraic on 0x8000|k<<2 gives 0xC000|k<<1.
    function automatic logic [127:0] bp_ra(input int k);
        return {8{16'h8000 | 16'(k << 2)}};
    endfunction

    function automatic logic [127:0] bp_exp(input int k);
        return {8{16'hC000 | 16'(k << 1)}};
    endfunction

    initial begin
        int nxt;
        int rcv;
        logic acc;

        rst = 1'b1;
        bus_if.out_ready = 1'b1;
        drive(1'b0, 1'b0, 7'h00, 128'h0, 7'h00);
        #2;
        check("rst_out_valid", 128'(bus_if.out_valid), 128'(0));
        check("rst_out_rt", bus_if.out_rt, 128'h0);
        check("rst_out_addr", 128'(bus_if.out_rt_addr), 128'(0));
        check("rst_in_ready", 128'(bus_if.in_ready), 128'(1));
        @(negedge clk);
        rst = 1'b0;

        op_check("cnt1_log", 1'b0, 7'h7F, {8{16'h8001}}, 7'd10, {8{16'h4000}});
        op_check("cnt1_alg", 1'b1, 7'h7F, {8{16'h8001}}, 7'd11, {8{16'hC000}});
        op_check("cnt0_log", 1'b0, 7'h00, LANE_RA, 7'd12, LANE_RA);
        op_check("cnt0_alg", 1'b1, 7'h40, LANE_RA, 7'd13, LANE_RA);
        op_check("cnt15_log", 1'b0, 7'h71, {8{16'h8000}}, 7'd14, {8{16'h0001}});
        op_check("cnt15_alg", 1'b1, 7'h71, {8{16'h8000}}, 7'd15, {8{16'hFFFF}});
        op_check("cnt16_log", 1'b0, 7'h70, {4{16'h8000, 16'h7FFF}}, 7'd16, 128'h0);
        op_check("cnt16_alg", 1'b1, 7'h70, {4{16'h8000, 16'h7FFF}}, 7'd17,
                 {4{16'hFFFF, 16'h0000}});
        op_check("cnt8_alg", 1'b1, 7'h78, {8{16'h8001}}, 7'd18, {8{16'hFF80}});
        op_check("cnt8_log", 1'b0, 7'h78, {8{16'h8001}}, 7'd19, {8{16'h0080}});
        op_check("cnt12_alg", 1'b1, 7'h74, {8{16'h8001}}, 7'd20, {8{16'hFFF8}});
        op_check("cnt31_alg", 1'b1, 7'h01, {8{16'h8001}}, 7'd21, {8{16'hFFFF}});
        op_check("lane_iso", 1'b0, 7'h7C, LANE_RA, 7'd22, LANE_EXP);

        // Backpressure: out_ready low for cycles 2..5 of the stream.
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b1;
        nxt = 1;
        rcv = 0;
        drive(1'b1, 1'b1, 7'h7F, bp_ra(1), 7'(1));
        for (int cyc = 0; cyc < 40 && rcv < 5; cyc++) begin
            @(negedge clk);
            if (cyc >= 2 && cyc < 6)
                check("bp_stall_in_ready", 128'(bus_if.in_ready), 128'(0));
            if (cyc == 6)
                check("bp_release_in_ready", 128'(bus_if.in_ready), 128'(1));
            if (bus_if.out_valid) begin
                check("bp_addr", 128'(bus_if.out_rt_addr), 128'(rcv + 1));
                check("bp_rt", bus_if.out_rt, bp_exp(rcv + 1));
                if (bus_if.out_ready)
                    rcv++;
            end
            acc = bus_if.in_valid && bus_if.in_ready;
            @(posedge clk);
            #1;
            if (acc)
                nxt++;
            bus_if.out_ready = !((cyc + 1) >= 2 && (cyc + 1) < 6);
            if (nxt <= 5)
                drive(1'b1, 1'b1, 7'h7F, bp_ra(nxt), 7'(nxt));
            else
                bus_if.in_valid = 1'b0;
        end
        bus_if.in_valid = 1'b0;
        check("bp_received", 128'(rcv), 128'(5));
        check("bp_sent", 128'(nxt - 1), 128'(5));
        @(negedge clk);
        check("bp_no_dup0", 128'(bus_if.out_valid), 128'(0));
        @(negedge clk);
        check("bp_no_dup1", 128'(bus_if.out_valid), 128'(0));

        // Fill the pipe with writeback stalled, then reset mid-stream.
        @(negedge clk);
        bus_if.out_ready = 1'b0;
        drive(1'b1, 1'b0, 7'h7F, {8{16'h1234}}, 7'd40);
        @(negedge clk);
        drive(1'b1, 1'b0, 7'h7F, {8{16'h5678}}, 7'd41);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        check("mid_full_valid", 128'(bus_if.out_valid), 128'(1));
        check("mid_full_in_ready", 128'(bus_if.in_ready), 128'(0));
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 128'(bus_if.out_valid), 128'(0));
        check("mid_rst_rt", bus_if.out_rt, 128'h0);
        check("mid_rst_addr", 128'(bus_if.out_rt_addr), 128'(0));
        check("mid_rst_in_ready", 128'(bus_if.in_ready), 128'(1));
        @(negedge clk);
        rst = 1'b0;
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_idle0", 128'(bus_if.out_valid), 128'(0));
        @(negedge clk);
        check("post_rst_idle1", 128'(bus_if.out_valid), 128'(0));
        op_check("post_rst_op", 1'b1, 7'h7F, {8{16'h8001}}, 7'd42, {8{16'hC000}});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
